icache_sa: RTL

- Parametrised set-associative instruction cache for the fetch stage. Successor to the 32-entry direct-mapped, one-word-line I-cache.
- Adds configurable ways, sets and words per line, with multi-word line refill from instruction SRAM and round-robin replacement.
- Adds whole-cache invalidate and a dual-fetch second-slot lookup that may cross a line boundary.
- Sits between the PC/IF stage and the SRAM bridge. Stalls the pipeline on a miss.

---
 rtl/icache_pkg.sv | 42 ++++
 rtl/icache_sa_if.sv | 12 +
 rtl/icache_tag_cmp.sv | 27 ++
 rtl/icache_sa.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the set-associative I-cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    FILL_DONE
  } state_e;

  function automatic int unsigned off_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned sets,
                                        input int unsigned line_words);
    return addr_w - 2 - off_w(line_words) - idx_w(sets);
  endfunction

  function automatic int unsigned way_w(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Field extractors work on a 64-bit view so a zero-width offset never appears.
  function automatic logic [63:0] get_off(input logic [63:0] a, input int unsigned line_words);
    return (a >> 2) & 64'(line_words - 1);
  endfunction

  function automatic logic [63:0] get_idx(input logic [63:0] a, input int unsigned line_words,
                                          input int unsigned sets);
    return (a >> (2 + off_w(line_words))) & 64'(sets - 1);
  endfunction

  function automatic logic [63:0] get_tag(input logic [63:0] a, input int unsigned line_words,
                                          input int unsigned sets);
    return a >> (2 + off_w(line_words) + idx_w(sets));
  endfunction

endpackage

// File: rtl/icache_sa_if.sv
// Refill bus between the I-cache and the instruction SRAM bridge.
interface icache_sa_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              sram_req_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic              sram_ready_i;
  logic [31:0]       sram_rdata_i;

  modport master (output sram_req_o, output sram_addr_o, input sram_ready_i, input sram_rdata_i);
  modport slave  (input sram_req_o, input sram_addr_o, output sram_ready_i, output sram_rdata_i);
endinterface

// File: rtl/icache_tag_cmp.sv
// Parallel tag/valid compare across all ways of one set.
module icache_tag_cmp
  import icache_pkg::*;
#(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned TAG_W = 24,
  localparam int unsigned WAY_W = way_w(WAYS)
) (
  input  logic [WAYS-1:0][TAG_W-1:0] tags_i,
  input  logic [WAYS-1:0]            valid_i,
  input  logic [TAG_W-1:0]           tag_i,
  output logic [WAYS-1:0]            hit_vec_o,
  output logic [WAY_W-1:0]           hit_way_o
);

  always_comb begin
    hit_vec_o = '0;
    hit_way_o = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_i[w] && (tags_i[w] == tag_i)) begin
        hit_vec_o[w] = 1'b1;
        hit_way_o    = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/icache_sa.sv
// Set-associative I-cache with multi-word refill, round-robin replacement and dual fetch.
// Optional ICACHE_PERF_EN adds saturating hit/miss counters.
module icache_sa
  import icache_pkg::*;
#(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rom_addr_i,
  input  logic              rom_ce_i,
  input  logic              branch,
  input  logic              inv_i,
  output logic [31:0]       inst_o,
  output logic [31:0]       inst2_o,
  output logic              inst2_valid,
  output logic              stall,
  output logic              Icache_hit,
  output logic              Icache_active,
`ifdef ICACHE_PERF_EN
  output logic [31:0]       perf_hit_cnt,
  output logic [31:0]       perf_miss_cnt,
`endif
  icache_sa_if.master       sram
);

  localparam int unsigned OFF_W = off_w(LINE_WORDS);
  localparam int unsigned IDX_W = idx_w(SETS);
  localparam int unsigned TAG_W = tag_w(ADDR_W, SETS, LINE_WORDS);
  localparam int unsigned WAY_W = way_w(WAYS);
  localparam int unsigned CNT_W = (OFF_W > 0) ? OFF_W : 1;
  localparam int unsigned WA_W  = IDX_W + CNT_W;

  logic [WAYS-1:0][SETS-1:0] valid_q;
  logic [TAG_W-1:0]          tag_q  [WAYS][SETS];
  logic [31:0]               data_q [WAYS][SETS*LINE_WORDS];
  logic [WAY_W-1:0]          rr_q   [SETS];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [WAY_W-1:0]  victim_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [ADDR_W-1:0] pc2;
  logic [IDX_W-1:0]  idx0, idx2, fidx;
  logic [CNT_W-1:0]  off0, off2;
  logic [TAG_W-1:0]  tag0, tag2, ftag;
  logic [WA_W-1:0]   widx0, widx2, fwidx;

  assign pc2   = rom_addr_i + ADDR_W'(4);
  assign idx0  = IDX_W'(get_idx(64'(rom_addr_i), LINE_WORDS, SETS));
  assign off0  = CNT_W'(get_off(64'(rom_addr_i), LINE_WORDS));
  assign tag0  = TAG_W'(get_tag(64'(rom_addr_i), LINE_WORDS, SETS));
  assign idx2  = IDX_W'(get_idx(64'(pc2), LINE_WORDS, SETS));
  assign off2  = CNT_W'(get_off(64'(pc2), LINE_WORDS));
  assign tag2  = TAG_W'(get_tag(64'(pc2), LINE_WORDS, SETS));
  assign fidx  = IDX_W'(get_idx(64'(base_q), LINE_WORDS, SETS));
  assign ftag  = TAG_W'(get_tag(64'(base_q), LINE_WORDS, SETS));
  assign widx0 = WA_W'(idx0) * WA_W'(LINE_WORDS) + WA_W'(off0);
  assign widx2 = WA_W'(idx2) * WA_W'(LINE_WORDS) + WA_W'(off2);
  assign fwidx = WA_W'(fidx) * WA_W'(LINE_WORDS) + WA_W'(cnt_q);

  logic [WAYS-1:0][TAG_W-1:0] tags0, tags2;
  logic [WAYS-1:0]            vld0, vld2, hv0, hv2;
  logic [WAY_W-1:0]           hw0, hw2;
  logic                       hit0, hit2;

  always_comb begin
    tags0 = '0;
    tags2 = '0;
    vld0  = '0;
    vld2  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      tags0[w] = tag_q[w][idx0];
      tags2[w] = tag_q[w][idx2];
      vld0[w]  = valid_q[w][idx0];
      vld2[w]  = valid_q[w][idx2];
    end
  end

  icache_tag_cmp #(.WAYS(WAYS), .TAG_W(TAG_W)) u_cmp0 (
    .tags_i(tags0), .valid_i(vld0), .tag_i(tag0), .hit_vec_o(hv0), .hit_way_o(hw0)
  );

  icache_tag_cmp #(.WAYS(WAYS), .TAG_W(TAG_W)) u_cmp2 (
    .tags_i(tags2), .valid_i(vld2), .tag_i(tag2), .hit_vec_o(hv2), .hit_way_o(hw2)
  );

  assign hit0 = |hv0;
  assign hit2 = |hv2;

  // Lowest invalid way wins; the round-robin pointer only matters for a full set.
  logic [WAY_W-1:0] victim, rr_nxt;
  logic             all_valid;

  always_comb begin
    victim    = rr_q[idx0];
    all_valid = 1'b1;
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (!valid_q[w-1][idx0]) begin
        victim    = WAY_W'(w - 1);
        all_valid = 1'b0;
      end
    end
    rr_nxt = WAY_W'((32'(rr_q[idx0]) + 32'd1) % WAYS);
  end

  logic              start_miss, fill_we, fill_last, req;
  logic [ADDR_W-1:0] req_addr;

  always_comb begin
    state_d       = state_q;
    start_miss    = 1'b0;
    fill_we       = 1'b0;
    fill_last     = 1'b0;
    req           = 1'b0;
    req_addr      = '0;
    stall         = 1'b0;
    Icache_hit    = 1'b0;
    Icache_active = 1'b0;
    inst2_valid   = 1'b0;
    inst_o        = '0;
    inst2_o       = '0;
    case (state_q)
      IDLE: begin
        Icache_hit    = hit0 && !inv_i;
        Icache_active = hit0 && !inv_i && !branch;
        inst2_valid   = hit0 && hit2 && !inv_i;
        inst_o        = hit0 ? data_q[hw0][widx0] : '0;
        inst2_o       = inst2_valid ? data_q[hw2][widx2] : '0;
        if (rom_ce_i && !hit0 && !branch && !inv_i) begin
          start_miss = 1'b1;
          stall      = 1'b1;
          state_d    = REFILL;
        end
      end
      REFILL: begin
        stall     = !branch;
        req       = !branch && !inv_i;
        req_addr  = req ? (base_q + (ADDR_W'(cnt_q) << 2)) : '0;
        fill_we   = req && sram.sram_ready_i;
        fill_last = fill_we && (cnt_q == CNT_W'(LINE_WORDS - 1));
        if (inv_i || branch) state_d = IDLE;
        else if (fill_last)  state_d = FILL_DONE;
      end
      FILL_DONE: begin
        stall   = !branch;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!rst) stall = 1'b0;
  end

  assign sram.sram_req_o  = req;
  assign sram.sram_addr_o = req_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      base_q   <= '0;
      victim_q <= '0;
      cnt_q    <= '0;
      for (int unsigned s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      state_q <= state_d;
      if (start_miss) begin
        base_q                <= rom_addr_i & ~ADDR_W'(LINE_WORDS * 4 - 1);
        victim_q              <= victim;
        cnt_q                 <= '0;
        valid_q[victim][idx0] <= 1'b0;
        if (all_valid) rr_q[idx0] <= rr_nxt;
      end
      if (fill_we)   cnt_q <= cnt_q + 1'b1;
      if (fill_last) valid_q[victim_q][fidx] <= 1'b1;
      if (inv_i)     valid_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we)   data_q[victim_q][fwidx] <= sram.sram_rdata_i;
    if (fill_last) tag_q[victim_q][fidx]   <= ftag;
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (inv_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (rom_ce_i && Icache_hit && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 1'b1;
      if (start_miss && (miss_cnt_q != '1))            miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign perf_hit_cnt  = hit_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;
`endif

endmodule
